// File: rtl/icache_fetch_pkg.sv
// ============================================================================
// Module      : icache_fetch_pkg
// Description : Shared constants for the instruction-fetch cache: FSM state
//               encoding and the NOP returned on a miss.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_fetch_pkg;

    // Fetch FSM encoding (explicit width)
    localparam logic [0:0] ST_LOOKUP = 1'b0;
    localparam logic [0:0] ST_REFILL = 1'b1;

    // Instruction presented to IF/ID whenever no valid instruction is available
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage : icache_fetch_pkg

`default_nettype wire

// File: rtl/icache_array.sv
// ============================================================================
// Module      : icache_array
// Description : Direct-mapped valid/tag/data storage. Combinational read,
//               synchronous single-line write, synchronous clear-all of the
//               valid bits. Tag and data storage carry no reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_array #(
    parameter int LINES = 16,
    parameter int IW    = 4,
    parameter int TW    = 26
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          we_i,
    input  logic [IW-1:0] widx_i,
    input  logic [TW-1:0] wtag_i,
    input  logic [31:0]   wdata_i,
    input  logic [IW-1:0] ridx_i,
    output logic          rvalid_o,
    output logic [TW-1:0] rtag_o,
    output logic [31:0]   rdata_o
);

    logic [LINES-1:0] valid_q;
    logic [TW-1:0]    tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    // Valid bits: clear-all dominates a write landing in the same cycle
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[widx_i] <= 1'b1;
        end
    end

    // Tag/data payload: written on refill, never reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[widx_i]  <= wtag_i;
            data_q[widx_i] <= wdata_i;
        end
    end

    assign rvalid_o = valid_q[ridx_i];
    assign rtag_o   = tag_q[ridx_i];
    assign rdata_o  = data_q[ridx_i];

endmodule : icache_array

`default_nettype wire

// File: rtl/icache_fetch.sv
// ============================================================================
// Module      : icache_fetch
// Description : Instruction fetch stage with a direct-mapped one-word-per-line
//               cache. Same-cycle hit in LOOKUP, single-word refill from
//               instruction memory in REFILL, redirects during a refill are
//               parked and applied when the refill completes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_fetch
    import icache_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          LINES    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        inval,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        hit,
    output logic [31:0] adder_out,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out
);

    localparam int IW = $clog2(LINES);
    localparam int TW = 32 - 2 - IW;

    logic [0:0]    state_q,     state_d;
    logic [31:0]   pc_q,        pc_d;
    logic [31:0]   addr_q,      addr_d;
    logic          pend_v_q,    pend_v_d;
    logic [31:0]   pend_pc_q,   pend_pc_d;

    logic [IW-1:0] w_idx;
    logic [TW-1:0] w_tag;
    logic          w_rvalid;
    logic [TW-1:0] w_rtag;
    logic [31:0]   w_rdata;
    logic          w_hit;
    logic          w_we;
    logic [31:0]   w_pc_plus4;

    assign w_idx      = pc_q[2+IW-1:2];
    assign w_tag      = pc_q[31:2+IW];
    assign w_pc_plus4 = pc_q + 32'd4;

    // Hit is suppressed outside LOOKUP, under reset and while invalidating
    assign w_hit = (state_q == ST_LOOKUP) && !rst && !inval &&
                   w_rvalid && (w_rtag == w_tag);

    // An invalidate coincident with the returning word discards that word
    assign w_we = (state_q == ST_REFILL) && mem_ack && !inval && !rst;

    icache_array #(
        .LINES (LINES),
        .IW    (IW),
        .TW    (TW)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (inval),
        .we_i     (w_we),
        .widx_i   (addr_q[2+IW-1:2]),
        .wtag_i   (addr_q[31:2+IW]),
        .wdata_i  (mem_rdata),
        .ridx_i   (w_idx),
        .rvalid_o (w_rvalid),
        .rtag_o   (w_rtag),
        .rdata_o  (w_rdata)
    );

    // Next-state: PC sequencing, refill launch/completion, parked redirect
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        pend_v_d  = pend_v_q;
        pend_pc_d = pend_pc_q;
        if (state_q == ST_LOOKUP) begin
            if (redirect) begin
                pc_d = redirect_pc;
            end else if (!inval) begin
                if (w_hit) begin
                    if (!stall) begin
                        pc_d = w_pc_plus4;
                    end
                end else begin
                    state_d = ST_REFILL;
                    addr_d  = {pc_q[31:2], 2'b00};
                end
            end
        end else begin
            if (mem_ack) begin
                state_d  = ST_LOOKUP;
                pend_v_d = 1'b0;
                // A redirect arriving with the ack is the most recent one
                if (redirect) begin
                    pc_d = redirect_pc;
                end else if (pend_v_q) begin
                    pc_d = pend_pc_q;
                end
            end else if (redirect) begin
                pend_v_d  = 1'b1;
                pend_pc_d = redirect_pc;
            end
        end
    end

    // State registers with synchronous reset; reset aborts any refill
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_LOOKUP;
            pc_q      <= RESET_PC;
            addr_q    <= 32'h0000_0000;
            pend_v_q  <= 1'b0;
            pend_pc_q <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            pend_v_q  <= pend_v_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign mem_req         = (state_q == ST_REFILL);
    assign mem_addr        = addr_q;
    assign hit             = w_hit;
    assign pc_out          = pc_q;
    assign adder_out       = w_pc_plus4;
    assign instruction_out = w_hit ? w_rdata : NOP_INSTR;

endmodule : icache_fetch

`default_nettype wire

// File: tb/tb_icache_fetch.sv
// ============================================================================
// Module      : tb_icache_fetch
// Description : Scoreboard bench for icache_fetch. A transaction-level model
//               (cache = map index -> cached word address, memory = hash of
//               address) predicts every cycle's outputs; a monitor compares.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          LINES    = 16;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inval;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        hit;
    logic [31:0] adder_out;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;

    icache_fetch #(
        .RESET_PC (RESET_PC),
        .LINES    (LINES)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .inval           (inval),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .hit             (hit),
        .adder_out       (adder_out),
        .instruction_out (instruction_out),
        .pc_out          (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hit;
        logic [31:0] pc;
        logic [31:0] adder;
        logic [31:0] instr;
        logic        req;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc      = RESET_PC;
    bit          m_refill  = 1'b0;
    logic [31:0] m_raddr   = 32'h0;
    bit          m_pend    = 1'b0;
    logic [31:0] m_pend_pc = 32'h0;
    logic [31:0] m_line [int];   // index -> word address held; absent = invalid

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] p;
        p = a * 32'h9E37_79B1;
        return p ^ 32'h5A5A_1234;
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 2) % LINES);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("hit", {31'd0, hit}, {31'd0, e.hit});
            check("pc_out", pc_out, e.pc);
            check("adder_out", adder_out, e.adder);
            check("instruction_out", instruction_out, e.instr);
            check("mem_req", {31'd0, mem_req}, {31'd0, e.req});
            if (e.req) check("mem_addr", mem_addr, e.addr);
        end
    end

    // Drive one cycle, predict its outputs, then advance the model at the edge
    task automatic do_cycle(input bit r, input bit st, input bit rd,
                            input logic [31:0] rpc, input bit inv, input bit ack);
        exp_t e;
        bit   h;
        int   idx;
        rst         = r;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        inval       = inv;
        mem_ack     = ack;
        mem_rdata   = (m_refill && ack) ? mem_word(m_raddr) : $urandom();
        idx = line_of(m_pc);
        h = !m_refill && !r && !inv && m_line.exists(idx) && (m_line[idx] == m_pc);
        e.hit   = h;
        e.pc    = m_pc;
        e.adder = m_pc + 32'd4;
        e.instr = h ? mem_word(m_pc) : 32'h0;
        e.req   = m_refill;
        e.addr  = m_raddr;
        sb.push_back(e);
        @(posedge clk);
        if (r) begin
            m_pc = RESET_PC; m_refill = 0; m_pend = 0; m_raddr = 32'h0;
            m_line.delete();
        end else if (!m_refill) begin
            if (inv) m_line.delete();
            if (rd) m_pc = rpc;
            else if (!inv) begin
                if (h) begin
                    if (!st) m_pc = m_pc + 32'd4;
                end else begin
                    m_refill = 1;
                    m_raddr  = {m_pc[31:2], 2'b00};
                end
            end
        end else begin
            if (inv) m_line.delete();
            if (ack) begin
                if (!inv) m_line[line_of(m_raddr)] = m_raddr;
                m_refill = 0;
                if (rd) m_pc = rpc;
                else if (m_pend) m_pc = m_pend_pc;
                m_pend = 0;
            end else if (rd) begin
                m_pend = 1; m_pend_pc = rpc;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 32'h0, 0, m_refill);
    endtask

    initial begin
        rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
        inval = 0; mem_ack = 0; mem_rdata = 0;
        @(posedge clk); #1;

        // Reset cycle, then cold start with ack two cycles after mem_req
        do_cycle(1, 0, 0, 32'h0, 0, 0);
        do_cycle(0, 0, 0, 32'h0, 0, 0);
        do_cycle(0, 0, 0, 32'h0, 0, 0);
        do_cycle(0, 0, 0, 32'h0, 0, 1);
        do_cycle(0, 0, 0, 32'h0, 0, 0);

        // Warm lines 1..3, return to 0 and stream hits
        idle(10);
        do_cycle(0, 0, 1, 32'h0, 0, 0);
        idle(4);

        // Stall on hit for three cycles, then advance
        do_cycle(0, 0, 1, 32'h4, 0, 0);
        for (int i = 0; i < 3; i++) do_cycle(0, 1, 0, 32'h0, 0, 0);
        idle(2);

        // Conflict miss: 0x40 evicts line 0, returning to 0x0 misses again
        do_cycle(0, 0, 1, 32'h40, 0, 0);
        idle(4);
        do_cycle(0, 0, 1, 32'h0, 0, 0);
        idle(4);

        // Redirect during refill, last redirect wins
        do_cycle(0, 0, 1, 32'h10, 0, 0);
        do_cycle(0, 0, 0, 32'h0, 0, 0);
        do_cycle(0, 0, 1, 32'h100, 0, 0);
        do_cycle(0, 1, 1, 32'h200, 0, 0);
        do_cycle(0, 0, 0, 32'h0, 0, 1);
        idle(3);
        do_cycle(0, 0, 1, 32'h10, 0, 0);
        idle(2);

        // inval with ack, then inval without ack, then rst mid-refill with ack
        do_cycle(0, 0, 1, 32'h80, 0, 0);
        do_cycle(0, 0, 0, 32'h0, 0, 0);
        do_cycle(0, 0, 0, 32'h0, 1, 1);
        do_cycle(0, 0, 0, 32'h0, 0, 0);
        do_cycle(0, 0, 0, 32'h0, 1, 0);
        do_cycle(0, 0, 0, 32'h0, 0, 1);
        do_cycle(0, 0, 0, 32'h0, 0, 0);
        do_cycle(0, 0, 1, 32'h84, 0, 0);
        do_cycle(0, 0, 0, 32'h0, 0, 0);
        do_cycle(1, 0, 0, 32'h0, 0, 1);
        idle(4);

        // PC+4 wrap at the top of the address space
        do_cycle(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        idle(5);

        // Randomised traffic, including mem_ack outside REFILL
        for (int i = 0; i < 4000; i++) begin
            bit          r, st, rd, inv, ack;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 199) == 0);
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            inv = ($urandom_range(0, 39) == 0);
            ack = ($urandom_range(0, 2) == 0);
            rpc = ($urandom_range(0, 49) == 0) ? 32'hFFFF_FFFC
                                               : (32'($urandom_range(0, 127)) << 2);
            do_cycle(r, st, rd, rpc, inv, ack);
        end

        @(negedge clk); #1;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_icache_fetch

`default_nettype wire

// File: doc/icache_fetch.md
ICACHE_FETCH -- requirements
Module: icache_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter LINES, default 16, number of direct-mapped one-word cache lines (power of two, 2..256).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard hold; PC does not advance while high.
REQ-006 redirect  input  1  branch/jump taken; load redirect_pc.
REQ-007 redirect_pc  input  32  target address, word aligned.
REQ-008 inval  input  1  invalidate all cache lines.
REQ-009 mem_req  output  1  refill request to instruction memory.
REQ-010 mem_addr  output  32  word-aligned refill address.
REQ-011 mem_ack  input  1  memory returns mem_rdata this cycle.
REQ-012 mem_rdata  input  32  refill data.
REQ-013 hit  output  1  instruction valid this cycle; drives the IF/ID hold-enable.
REQ-014 adder_out  output  32  PC+4 of current fetch, for IF/ID.
REQ-015 instruction_out  output  32  fetched instruction, for IF/ID.
REQ-016 pc_out  output  32  current fetch PC.

Function
REQ-017 Address split: offset PC[1:0] ignored; index = PC[2+IW-1:2], IW = log2(LINES); tag = PC[31:2+IW].
REQ-018 Storage per line: valid bit, tag, 32-bit data; no byte enables, read-only from the CPU side.
REQ-019 FSM states: LOOKUP, REFILL; reset state LOOKUP.
REQ-020 In LOOKUP, hit is combinational = valid[index] and tag match; no extra cycle of latency.
REQ-021 hit is 0 in REFILL, during rst, and in any cycle where inval is high.
REQ-022 instruction_out = line data when hit, else 32'h0000_0000 (NOP).
REQ-023 adder_out = pc_out + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0).
REQ-024 PC update priority, LOOKUP state: redirect -> PC <= redirect_pc; else hit and not stall -> PC <= PC+4; else hold.
REQ-025 redirect is honoured in LOOKUP regardless of hit or stall.
REQ-026 LOOKUP with miss, no redirect, no inval -> REFILL next cycle; mem_addr latched to {PC[31:2],2'b00}.
REQ-027 In REFILL, mem_req = 1 and mem_addr held constant until the cycle mem_ack is sampled high.
REQ-028 On mem_ack in REFILL: write data, tag, valid=1 at the latched index; mem_req drops next cycle; -> LOOKUP.
REQ-029 Line written on ack is visible in the following LOOKUP cycle (hit one cycle after ack).
REQ-030 redirect during REFILL: redirect_pc latched in a pending register (last one wins); refill still completes; on leaving REFILL PC <= pending target.
REQ-031 stall has no effect in REFILL; PC holds there unless REQ-030 applies.
REQ-032 inval in LOOKUP clears all valid bits at the edge; inval in REFILL clears all valid bits and also suppresses the write of the completing line if simultaneous with mem_ack.
REQ-033 inval in REFILL without ack: refill continues; arriving line written valid (it postdates the invalidate).
REQ-034 mem_ack outside REFILL is ignored.
REQ-035 Miss-to-hit latency with ack in the first REFILL cycle: 2 cycles (LOOKUP miss, REFILL+ack, LOOKUP hit).

Reset
REQ-036 On rst at a clock edge: PC <= RESET_PC, state <= LOOKUP, all valid <= 0, pending redirect cleared, mem_req <= 0.
REQ-037 rst in REFILL aborts the refill; a mem_ack in the same cycle is discarded.
REQ-038 Tag and data arrays need not be reset.

Structure
REQ-039 Shared package holds FSM state encoding and NOP constant 32'h0; LINES/IW derived locally.
REQ-040 One sub-module, icache_array: valid/tag/data storage with combinational read, synchronous write and clear-all.
REQ-041 Target size 150-300 lines RTL including icache_array.

Verification
REQ-042 Cold start: rst 1 cycle, mem_ack 2 cycles after each mem_req -> mem_addr 0x0, hit 0 for 3 cycles, then hit=1, adder_out=0x4.
REQ-043 Sequential hits: preload lines 0..3, stall=0 -> pc_out 0x0,0x4,0x8,0xC on consecutive cycles, hit held 1.
REQ-044 Conflict miss: LINES=16, fetch 0x0 then redirect to 0x40 -> miss, mem_addr 0x40, line 0 replaced; return to 0x0 misses again.
REQ-045 Redirect during refill: miss at 0x10, redirect to 0x200 before ack -> line 0x10 written, next pc_out 0x200.
REQ-046 Stall on hit: hit=1, stall=1 for 3 cycles -> pc_out and instruction_out constant, then advance by 4.
REQ-047 inval with mem_ack same cycle, then rst mid-REFILL -> line not valid, refetch; after rst pc_out=RESET_PC, mem_req 0.
